dmem_ctrl: RTL and testbench
============================

# dmem_ctrl

Data-memory responder for the execute stage's load/store requests. It accepts one load or store per transaction and serialises it into byte accesses on the 8-bit external RAM bus, little-endian. Loaded data is sign- or zero-extended and returned with a one-cycle done pulse. It holds the pipeline stalled while a transaction is in flight.

## Interface
Parameters:
- ADDR_WIDTH, 32, width of request and RAM address.

Ports:
- clk_in  in  1  clock; all state updates on rising edge.
- rst_in  in  1  reset, synchronous, active-low.
- rdy_in  in  1  global run enable; low freezes the block.
- load_in  in  1  load request.
- store_in  in  1  store request; wins if load_in is also high.
- mem_addr_in  in  ADDR_WIDTH  byte address of the access.
- mem_val_in  in  32  store data; low bytes used per size.
- size_in  in  2  00 byte, 01 half, 10 word, 11 treated as word.
- unsigned_in  in  1  1 = zero-extend the load (LBU/LHU).
- rd_val_out  out  32  extended load result; valid while done_out is high.
- done_out  out  1  one-cycle completion pulse.
- misalign_out  out  1  misaligned-access flag; valid with done_out.
- stallreq_out  out  1  stall request to the pipeline control.
- ram_a_out  out  ADDR_WIDTH  RAM byte address.
- ram_dout  out  8  RAM write byte.
- ram_wr_out  out  1  1 = write, 0 = read.
- ram_din  in  8  RAM read byte for the address presented in the previous cycle.

## Operation
- States: IDLE, ACCESS, TAIL, DONE. N = 1, 2 or 4 bytes, taken from size_in.
- IDLE:
  - On load_in or store_in, latch the address, data, size and sign mode; clear cnt; go to ACCESS.
  - The requesting cycle is cycle 0.
- ACCESS, cycle k+1 (k = 0..N-1):
  - ram_a_out = base + k, modulo 2^ADDR_WIDTH.
  - Store: ram_wr_out = 1, ram_dout = data byte k.
  - Load: capture ram_din as byte k-1 when k > 0.
  - After k = N-1, a store goes to DONE and a load goes to TAIL.
- TAIL (load only):
  - Capture byte N-1.
  - ram_a_out holds the last address; ram_wr_out = 0. Go to DONE.
- DONE:
  - done_out = 1; rd_val_out is the extended result (0 for stores).
  - Go to IDLE. A request still present in DONE is not accepted.
- Extension: bytes 0..N-1 are assembled little-endian. Bit 8N-1 is replicated upward unless unsigned_in is set; size 10/11 is not extended.
- stallreq_out = (IDLE and a request present) or ACCESS or TAIL. It is low in DONE, so the pipeline advances at the end of the DONE cycle.
- Idle bus: ram_a_out = 0, ram_wr_out = 0, ram_dout = 0.

## Timing
- Latency from cycle 0 to done_out: load N+2 cycles (LB 3, LH 4, LW 6); store N+1 cycles (SB 2, SH 3, SW 5).
- rdy_in low:
  - State, cnt, captured bytes and all outputs freeze.
  - ram_wr_out is forced to 0 and ram_a_out holds its value.
  - The byte addressed before the pause is captured on the first rdy_in-high cycle.
  - No byte is written twice; a request seen in IDLE is not accepted.
- Reset (rst_in low at an edge):
  - The next state is IDLE and all registers clear.
  - ram_wr_out, ram_a_out, done_out and stallreq_out are gated to 0 in any cycle rst_in is low, including mid-transaction.
- Reset values: every output is 0.

## Configuration
- DMEM_MISALIGN_CHK_EN defined:
  - A half access with addr[0] = 1, or a word access with addr[1:0] != 0, does not touch the RAM.
  - The FSM goes IDLE -> DONE; done_out and misalign_out are high in cycle 1 and rd_val_out = 0.
- DMEM_MISALIGN_CHK_EN undefined: misaligned accesses proceed byte-wise normally; misalign_out is tied to 0.

## Test plan
- LW at 0x100, RAM 0x100..0x103 = 11 22 33 44: ram_a_out 0x100..0x103 in cycles 1-4, done_out in cycle 6, rd_val_out = 0x44332211, stallreq_out high in cycles 0-5.
- LB at 0x205 with byte 0x80: rd_val_out = 0xFFFFFF80, done in cycle 3. LBU at the same address: 0x00000080. LH at 0x206 with 0x7F 0x80: 0xFFFF807F.
- SH of 0xDEADBEEF at 0x300: EF written at 0x300 in cycle 1, BE at 0x301 in cycle 2, done in cycle 3, exactly two write cycles. SW at 0xFFFFFFFE: writes to 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1.
- LW as in the first test with rdy_in low in cycles 2-4: same result, done in cycle 9. SW with the same pause: four write cycles total, none during the pause.
- rst_in low in cycle 2 of an SW: ram_wr_out = 0 that cycle, all outputs 0 on the next cycle, and a new LB is then accepted normally.
- LW at 0x102: with DMEM_MISALIGN_CHK_EN, done_out and misalign_out in cycle 1 and no RAM access. Without it, a normal 4-byte read from 0x102..0x105, done in cycle 6.

Source files
------------

// File: rtl/dmem_ctrl.sv
// Data-memory responder: serialises loads/stores onto an 8-bit RAM bus.
// Optional misaligned-access trap: define DMEM_MISALIGN_CHK_EN.
module dmem_ctrl #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  load_in,
  input  logic                  store_in,
  input  logic [ADDR_WIDTH-1:0] mem_addr_in,
  input  logic [31:0]           mem_val_in,
  input  logic [1:0]            size_in,
  input  logic                  unsigned_in,
  output logic [31:0]           rd_val_out,
  output logic                  done_out,
  output logic                  misalign_out,
  output logic                  stallreq_out,
  output logic [ADDR_WIDTH-1:0] ram_a_out,
  output logic [7:0]            ram_dout,
  output logic                  ram_wr_out,
  input  logic [7:0]            ram_din
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    TAIL,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0] data_q;
  logic [31:0] rdata_q;
  logic [1:0]  size_q;
  logic [1:0]  cnt_q;
  logic        uns_q;
  logic        st_q;
  logic        paused_q;
  logic [7:0]  hold_q;

  logic        req;
  logic        mis_req;
  logic [1:0]  last_idx;
  logic        last;
  logic        busy;
  logic        cap;
  logic [1:0]  cap_idx;
  logic [7:0]  din_eff;
  logic [31:0] ext;

  assign req = load_in | store_in;

`ifdef DMEM_MISALIGN_CHK_EN
  logic mis_q;
  assign mis_req = (size_in == 2'b01 && mem_addr_in[0])
                 | (size_in[1] && mem_addr_in[1:0] != 2'b00);
`else
  assign mis_req = 1'b0;
`endif

  always_comb begin
    last_idx = 2'd3;
    unique case (1'b1)
      size_q == 2'b00: last_idx = 2'd0;
      size_q == 2'b01: last_idx = 2'd1;
      size_q[1]:       last_idx = 2'd3;
    endcase
  end

  assign last    = cnt_q == last_idx;
  assign busy    = state == ACCESS || state == TAIL;
  assign cap     = (state == ACCESS && !st_q && cnt_q != 2'd0)
                 || state == TAIL;
  assign cap_idx = (state == TAIL) ? cnt_q : cnt_q - 2'd1;
  // The byte in flight when a pause begins is parked until the run resumes.
  assign din_eff = paused_q ? hold_q : ram_din;

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state    <= IDLE;
      addr_q   <= '0;
      data_q   <= '0;
      rdata_q  <= '0;
      size_q   <= '0;
      cnt_q    <= '0;
      uns_q    <= 1'b0;
      st_q     <= 1'b0;
      paused_q <= 1'b0;
      hold_q   <= '0;
`ifdef DMEM_MISALIGN_CHK_EN
      mis_q    <= 1'b0;
`endif
    end else begin
      paused_q <= ~rdy_in;
      if (!rdy_in && !paused_q)
        hold_q <= ram_din;
      if (rdy_in) begin
        state <= state_nx;
        if (state == IDLE && req) begin
          addr_q  <= mem_addr_in;
          data_q  <= mem_val_in;
          size_q  <= size_in;
          uns_q   <= unsigned_in;
          st_q    <= store_in;
          cnt_q   <= 2'd0;
          rdata_q <= '0;
`ifdef DMEM_MISALIGN_CHK_EN
          mis_q   <= mis_req;
`endif
        end
        if (state == ACCESS && !last)
          cnt_q <= cnt_q + 2'd1;
        if (cap)
          rdata_q[{cap_idx, 3'b000} +: 8] <= din_eff;
      end
    end
  end

  always_comb begin
    state_nx = state;
    if (rdy_in) begin
      unique case (state)
        IDLE:    if (req) state_nx = mis_req ? DONE : ACCESS;
        ACCESS:  if (last) state_nx = st_q ? DONE : TAIL;
        TAIL:    state_nx = DONE;
        DONE:    state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    ext = rdata_q;
    unique case (size_q)
      2'b00:   ext = {{24{~uns_q & rdata_q[7]}}, rdata_q[7:0]};
      2'b01:   ext = {{16{~uns_q & rdata_q[15]}}, rdata_q[15:0]};
      default: ext = rdata_q;
    endcase
  end

  always_comb begin
    ram_a_out    = '0;
    ram_dout     = 8'h00;
    ram_wr_out   = 1'b0;
    done_out     = 1'b0;
    stallreq_out = 1'b0;
    rd_val_out   = '0;
    misalign_out = 1'b0;
    if (rst_in) begin
      if (busy)
        ram_a_out = addr_q + ADDR_WIDTH'(cnt_q);
      if (state == ACCESS && st_q) begin
        ram_dout   = data_q[{cnt_q, 3'b000} +: 8];
        ram_wr_out = rdy_in;
      end
      done_out     = state == DONE;
      stallreq_out = (state == IDLE && req) || busy;
      if (state == DONE && !st_q)
        rd_val_out = ext;
`ifdef DMEM_MISALIGN_CHK_EN
      misalign_out = state == DONE && mis_q;
`endif
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl with a synchronous byte-RAM model.
// Expected values are hand-computed constants.
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst_in = 1'b0;
  logic        rdy_in = 1'b1;
  logic        load_in = 1'b0;
  logic        store_in = 1'b0;
  logic [31:0] mem_addr_in = '0;
  logic [31:0] mem_val_in = '0;
  logic [1:0]  size_in = '0;
  logic        unsigned_in = 1'b0;
  logic [31:0] rd_val_out;
  logic        done_out;
  logic        misalign_out;
  logic        stallreq_out;
  logic [31:0] ram_a_out;
  logic [7:0]  ram_dout;
  logic        ram_wr_out;
  logic [7:0]  ram_din = 8'h00;

  always #5 clk = ~clk;

  dmem_ctrl #(.ADDR_WIDTH(32)) dut (
    .clk_in(clk),
    .rst_in(rst_in),
    .rdy_in(rdy_in),
    .load_in(load_in),
    .store_in(store_in),
    .mem_addr_in(mem_addr_in),
    .mem_val_in(mem_val_in),
    .size_in(size_in),
    .unsigned_in(unsigned_in),
    .rd_val_out(rd_val_out),
    .done_out(done_out),
    .misalign_out(misalign_out),
    .stallreq_out(stallreq_out),
    .ram_a_out(ram_a_out),
    .ram_dout(ram_dout),
    .ram_wr_out(ram_wr_out),
    .ram_din(ram_din)
  );

  logic [7:0] mem [logic [31:0]];

  always @(posedge clk) begin
    ram_din <= mem.exists(ram_a_out) ? mem[ram_a_out] : 8'h00;
    if (ram_wr_out)
      mem[ram_a_out] = ram_dout;
  end

  int checks = 0;
  int errors = 0;

  int          done_cyc;
  logic [31:0] rd_res;
  logic        mis_res;
  logic [15:0] stall_h;
  logic [15:0] wr_h;
  logic [31:0] a_h [16];
  logic [31:0] wa [$];
  logic [7:0]  wd [$];
  logic        rst_obs;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run(input logic st, input logic ld,
                     input logic [31:0] a, input logic [31:0] v,
                     input logic [1:0] sz, input logic u,
                     input logic [15:0] pause, input int rc);
    done_cyc = -1;
    rd_res   = '0;
    mis_res  = 1'b0;
    stall_h  = '0;
    wr_h     = '0;
    rst_obs  = 1'b0;
    wa.delete();
    wd.delete();
    for (int c = 0; c < 16; c++) begin
      @(posedge clk);
      #1;
      store_in    = st & (c == 0);
      load_in     = ld & (c == 0);
      mem_addr_in = a;
      mem_val_in  = v;
      size_in     = sz;
      unsigned_in = u;
      rdy_in      = ~pause[c];
      rst_in      = (c != rc);
      @(negedge clk);
      a_h[c]     = ram_a_out;
      stall_h[c] = stallreq_out;
      wr_h[c]    = ram_wr_out;
      if (ram_wr_out) begin
        wa.push_back(ram_a_out);
        wd.push_back(ram_dout);
      end
      if (done_out && done_cyc < 0) begin
        done_cyc = c;
        rd_res   = rd_val_out;
        mis_res  = misalign_out;
      end
      if (c == rc + 1)
        rst_obs = |{rd_val_out, done_out, misalign_out, stallreq_out,
                    ram_a_out, ram_dout, ram_wr_out};
    end
    @(posedge clk);
    #1;
    rdy_in = 1'b1;
    rst_in = 1'b1;
  endtask

  initial begin
    mem[32'h100] = 8'h11;
    mem[32'h101] = 8'h22;
    mem[32'h102] = 8'h33;
    mem[32'h103] = 8'h44;
    mem[32'h104] = 8'h55;
    mem[32'h105] = 8'h66;
    mem[32'h205] = 8'h80;
    mem[32'h206] = 8'h7F;
    mem[32'h207] = 8'h80;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outs", 64'(|{rd_val_out, done_out, misalign_out,
        stallreq_out, ram_a_out, ram_dout, ram_wr_out}), 64'd0);
    @(posedge clk);
    #1;
    rst_in = 1'b1;
    @(negedge clk);
    chk("post_reset_idle", 64'(|{done_out, stallreq_out, ram_wr_out,
        ram_a_out}), 64'd0);

    run(1'b0, 1'b1, 32'h100, 32'h0, 2'b10, 1'b0, 16'h0, 99);
    chk("lw_done", 64'(done_cyc), 64'd6);
    chk("lw_val", 64'(rd_res), 64'h44332211);
    chk("lw_addr", {a_h[1][15:0], a_h[2][15:0], a_h[3][15:0],
        a_h[4][15:0]}, 64'h0100_0101_0102_0103);
    chk("lw_stall", 64'(stall_h[7:0]), 64'h3F);
    chk("lw_nowrite", 64'(wr_h), 64'd0);

    run(1'b0, 1'b1, 32'h205, 32'h0, 2'b00, 1'b0, 16'h0, 99);
    chk("lb_done", 64'(done_cyc), 64'd3);
    chk("lb_val", 64'(rd_res), 64'hFFFFFF80);
    run(1'b0, 1'b1, 32'h205, 32'h0, 2'b00, 1'b1, 16'h0, 99);
    chk("lbu_val", 64'(rd_res), 64'h00000080);
    run(1'b0, 1'b1, 32'h206, 32'h0, 2'b01, 1'b0, 16'h0, 99);
    chk("lh_done", 64'(done_cyc), 64'd4);
    chk("lh_val", 64'(rd_res), 64'hFFFF807F);
    run(1'b0, 1'b1, 32'h206, 32'h0, 2'b01, 1'b1, 16'h0, 99);
    chk("lhu_val", 64'(rd_res), 64'h0000807F);

    run(1'b1, 1'b0, 32'h300, 32'hDEADBEEF, 2'b01, 1'b0, 16'h0, 99);
    chk("sh_done", 64'(done_cyc), 64'd3);
    chk("sh_wr_cycles", 64'(wr_h), 64'h0006);
    chk("sh_mem", {mem[32'h300], mem[32'h301]}, 64'hEFBE);
    chk("sh_rd_zero", 64'(rd_res), 64'd0);

    run(1'b1, 1'b1, 32'hFFFFFFFE, 32'h04030201, 2'b10, 1'b0, 16'h0, 99);
    chk("sw_wrap_done", 64'(done_cyc), 64'd5);
    chk("sw_wrap_n", 64'(wa.size()), 64'd4);
    if (wa.size() == 4) begin
      chk("sw_wrap_a01", {wa[0], wa[1]}, 64'hFFFFFFFE_FFFFFFFF);
      chk("sw_wrap_a23", {wa[2], wa[3]}, 64'h00000000_00000001);
      chk("sw_wrap_d", {32'h0, wd[0], wd[1], wd[2], wd[3]},
          64'h01020304);
    end

    run(1'b0, 1'b1, 32'h100, 32'h0, 2'b10, 1'b0, 16'h001C, 99);
    chk("lw_pause_done", 64'(done_cyc), 64'd9);
    chk("lw_pause_val", 64'(rd_res), 64'h44332211);

    run(1'b1, 1'b0, 32'h500, 32'hCAFEF00D, 2'b10, 1'b0, 16'h001C, 99);
    chk("sw_pause_wr", 64'(wr_h), 64'h00E2);
    chk("sw_pause_done", 64'(done_cyc), 64'd8);
    chk("sw_pause_mem", {mem[32'h500], mem[32'h501], mem[32'h502],
        mem[32'h503]}, 64'h0DF0FECA);

    run(1'b1, 1'b0, 32'h400, 32'hA1B2C3D4, 2'b10, 1'b0, 16'h0, 2);
    chk("rst_mid_wr", 64'(wr_h[3:0]), 64'h2);
    chk("rst_mid_after", 64'(rst_obs), 64'd0);
    chk("rst_mid_nodone", 64'(done_cyc), 64'hFFFFFFFF_FFFFFFFF);
    run(1'b0, 1'b1, 32'h205, 32'h0, 2'b00, 1'b0, 16'h0, 99);
    chk("rst_then_lb_done", 64'(done_cyc), 64'd3);
    chk("rst_then_lb_val", 64'(rd_res), 64'hFFFFFF80);

    run(1'b0, 1'b1, 32'h102, 32'h0, 2'b10, 1'b0, 16'h0, 99);
`ifdef DMEM_MISALIGN_CHK_EN
    chk("mis_done", 64'(done_cyc), 64'd1);
    chk("mis_flag", 64'(mis_res), 64'd1);
    chk("mis_val", 64'(rd_res), 64'd0);
    chk("mis_noaddr", 64'(a_h[1] | a_h[2]), 64'd0);
`else
    chk("mis_done", 64'(done_cyc), 64'd6);
    chk("mis_flag", 64'(mis_res), 64'd0);
    chk("mis_val", 64'(rd_res), 64'h66554433);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
